// File: rtl/bnn_seq_layer_pkg.sv
// Shared definitions for the bnn layer blocks: FSM state type and the
// derivation helpers for accumulator width and beat count.
package bnn_seq_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bnn_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Enough headroom for N full-scale features of either sign.
    function automatic int acc_w(input int b, input int n);
        return b + clog2(n) + 1;
    endfunction

    function automatic int beats(input int n, input int p);
        return (n + p - 1) / p;
    endfunction

    // Counter width, never below one bit (N=1 / P=N cases).
    function automatic int cnt_w(input int v);
        return (clog2(v) > 0) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/bnn_seq_layer_if.sv
// Vector-in / result-out handshake bundle for one bnn layer.
interface bnn_seq_layer_if #(
    parameter int N = 4,
    parameter int B = 4,
    parameter int M = 4
);
    logic [N*B-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   out;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/bnn_seq_layer_mac_lane.sv
// One neuron: signed accumulator, P-lane add/subtract sum and threshold compare.
module bnn_mac_lane #(
    parameter int P     = 1,
    parameter int B     = 4,
    parameter int ACC_W = 7,
    parameter logic signed [ACC_W-1:0] THRESH = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [P*B-1:0] feat_i,
    input  logic [P-1:0]   wbit_i,
    input  logic [P-1:0]   lane_vld_i,
    input  logic           clear_i,
    input  logic           en_i,
    output logic           result_o
);
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] feat_ext;

    // Running sum including this beat's lanes; masked lanes add nothing.
    always_comb begin
        sum_d    = acc_q;
        feat_ext = '0;
        for (int k = 0; k < P; k++) begin
            feat_ext = $signed({{(ACC_W-B){1'b0}}, feat_i[k*B +: B]});
            if (lane_vld_i[k]) begin
                if (wbit_i[k]) sum_d = sum_d + feat_ext;
                else           sum_d = sum_d - feat_ext;
            end
        end
    end

    // The compare sees the sum with the current beat folded in, so the top can
    // latch the final result on the last RUN edge.
    assign result_o = (sum_d >= THRESH);

    // Accumulator: cleared on vector accept, updated every RUN beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          acc_q <= '0;
        else if (clear_i) acc_q <= '0;
        else if (en_i)    acc_q <= sum_d;
    end

endmodule

// File: rtl/bnn_seq_layer.sv
// Time-multiplexed binary-weight dense layer with per-neuron thresholds.
module bnn_seq_layer
    import bnn_seq_layer_pkg::*;
#(
    parameter int N = 4,
    parameter int B = 4,
    parameter int M = 4,
    parameter int P = 1,
    parameter logic [M*N-1:0]          WEIGHTS    = '0,
    parameter logic [M*acc_w(B,N)-1:0] THRESHOLDS = '0
) (
    input  logic           clk,
    input  logic           rst,
    bnn_seq_layer_if.slave bus
);
    localparam int ACC_W  = acc_w(B, N);
    localparam int BEATS  = beats(N, P);
    localparam int BEAT_W = cnt_w(BEATS);
    localparam int PAD    = BEATS * P;
    // Zero-padding the ragged tail keeps every lane index in range.
    localparam logic [PAD*M-1:0]  W_PAD     = (PAD*M)'(WEIGHTS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    bnn_state_e        state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [N*B-1:0]    data_q;
    logic [M-1:0]      out_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [M-1:0]      result;
    logic              accept;
    logic              last_beat;
    logic              run_en;
    logic [PAD*B-1:0]  data_pad;
    logic [P*B-1:0]    lane_feat;
    logic [P-1:0]      lane_vld;

    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_beat = (beat_q == LAST_BEAT);
    assign run_en    = (state_q == ST_RUN);
    assign data_pad  = (PAD*B)'(data_q);

    // Feature slice for the current beat; lanes past N are flagged invalid.
    always_comb begin
        lane_feat = '0;
        lane_vld  = '0;
        for (int k = 0; k < P; k++) begin
            lane_feat[k*B +: B] = data_pad[(int'(beat_q)*P + k)*B +: B];
            lane_vld[k]         = (int'(beat_q)*P + k) < N;
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_lane
        logic [P-1:0] wbit;

        // Weight bits for this neuron on the current beat's lanes.
        always_comb begin
            wbit = '0;
            for (int k = 0; k < P; k++) begin
                wbit[k] = W_PAD[(int'(beat_q)*P + k)*M + m];
            end
        end

        bnn_mac_lane #(
            .P      (P),
            .B      (B),
            .ACC_W  (ACC_W),
            .THRESH (THRESHOLDS[m*ACC_W +: ACC_W])
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .feat_i     (lane_feat),
            .wbit_i     (wbit),
            .lane_vld_i (lane_vld),
            .clear_i    (accept),
            .en_i       (run_en),
            .result_o   (result[m])
        );
    end

    // Sequencer: capture, step through beats, hold the result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            data_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data_q  <= bus.in_data;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_beat) begin
                        beat_q      <= '0;
                        out_q       <= result;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            data_q  <= bus.in_data;
                            beat_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_layer.sv
// Bench for bnn_seq_layer: four configurations checked against an integer model.
module tb_bnn_seq_layer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0][15:0] in_data_v;
    logic [3:0]       in_valid_v;
    logic [3:0]       out_ready_v;
    wire  [3:0]       in_ready_v;
    wire  [3:0]       out_valid_v;
    wire  [3:0]       busy_v;
    wire  [3:0][3:0]  out_v;

    int checks = 0;
    int passes = 0;

    // Configuration table used by the reference model.
    localparam int          M_T     [4] = '{2, 2, 2, 4};
    localparam int          BEATS_T [4] = '{4, 2, 1, 2};
    localparam logic [15:0] W_T     [4] = '{16'h0077, 16'h0077, 16'h00FF, 16'hCCCC};
    localparam logic [27:0] TH_T    [4] = '{28'h0, 28'h0, {14'h0, 7'd18, 7'd17},
                                            {7'd61, 7'd60, 7'd69, 7'd68}};

    bnn_seq_layer_if #(.N(4), .B(4), .M(2)) if0 ();
    bnn_seq_layer_if #(.N(4), .B(4), .M(2)) if1 ();
    bnn_seq_layer_if #(.N(4), .B(4), .M(2)) if2 ();
    bnn_seq_layer_if #(.N(4), .B(4), .M(4)) if3 ();

    assign if0.in_data = in_data_v[0]; assign if0.in_valid = in_valid_v[0]; assign if0.out_ready = out_ready_v[0];
    assign if1.in_data = in_data_v[1]; assign if1.in_valid = in_valid_v[1]; assign if1.out_ready = out_ready_v[1];
    assign if2.in_data = in_data_v[2]; assign if2.in_valid = in_valid_v[2]; assign if2.out_ready = out_ready_v[2];
    assign if3.in_data = in_data_v[3]; assign if3.in_valid = in_valid_v[3]; assign if3.out_ready = out_ready_v[3];

    assign in_ready_v[0] = if0.in_ready; assign out_valid_v[0] = if0.out_valid; assign busy_v[0] = if0.busy; assign out_v[0] = {2'b00, if0.out};
    assign in_ready_v[1] = if1.in_ready; assign out_valid_v[1] = if1.out_valid; assign busy_v[1] = if1.busy; assign out_v[1] = {2'b00, if1.out};
    assign in_ready_v[2] = if2.in_ready; assign out_valid_v[2] = if2.out_valid; assign busy_v[2] = if2.busy; assign out_v[2] = {2'b00, if2.out};
    assign in_ready_v[3] = if3.in_ready; assign out_valid_v[3] = if3.out_valid; assign busy_v[3] = if3.busy; assign out_v[3] = if3.out;

    // P=1, thresholds 0, neuron1 weights 1,0,1,0
    bnn_seq_layer #(.N(4), .B(4), .M(2), .P(1), .WEIGHTS(8'h77), .THRESHOLDS(14'h0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    // Same weights, P=3: ragged second beat
    bnn_seq_layer #(.N(4), .B(4), .M(2), .P(3), .WEIGHTS(8'h77), .THRESHOLDS(14'h0))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    // All-add, thresholds 17 / 18, P=N
    bnn_seq_layer #(.N(4), .B(4), .M(2), .P(4), .WEIGHTS(8'hFF), .THRESHOLDS({7'd18, 7'd17}))
        dut2 (.clk(clk), .rst(rst), .bus(if2));
    // Extremes: sub/-60, sub/-59, add/60, add/61
    bnn_seq_layer #(.N(4), .B(4), .M(4), .P(2), .WEIGHTS(16'hCCCC),
                    .THRESHOLDS({7'd61, 7'd60, 7'd69, 7'd68}))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    function automatic logic [3:0] model(input int d, input logic [15:0] x);
        logic [3:0]        r;
        logic [15:0]       w;
        logic [27:0]       th;
        logic signed [6:0] tv;
        int                s;
        r  = '0;
        w  = W_T[d];
        th = TH_T[d];
        for (int m = 0; m < M_T[d]; m++) begin
            s = 0;
            for (int n = 0; n < 4; n++) begin
                if (w[n*M_T[d] + m]) s += int'(x[n*4 +: 4]);
                else                 s -= int'(x[n*4 +: 4]);
            end
            tv   = th[m*7 +: 7];
            r[m] = (s >= int'(tv));
        end
        return r;
    endfunction

    task automatic wait_valid(input int d, output int k);
        k = 0;
        while (out_valid_v[d] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // One full transaction on device d, expecting result exp.
    task automatic run_vec(input int d, input logic [15:0] x, input logic [3:0] exp);
        int k;
        k = 0;
        while (in_ready_v[d] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (in_ready_v[d] !== 1'b1) $display("FAIL in_ready_idle d%0d: got %b expected 1", d, in_ready_v[d]);
        else passes++;
        in_data_v[d]   = x;
        in_valid_v[d]  = 1'b1;
        out_ready_v[d] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        in_data_v[d]  = 16'($urandom);
        checks++;
        if (busy_v[d] !== 1'b1 || in_ready_v[d] !== 1'b0)
            $display("FAIL run_flags d%0d: got busy=%b in_ready=%b expected busy=1 in_ready=0", d, busy_v[d], in_ready_v[d]);
        else passes++;
        wait_valid(d, k);
        checks++;
        if (k !== BEATS_T[d]) $display("FAIL latency d%0d: got %0d expected %0d", d, k, BEATS_T[d]);
        else passes++;
        checks++;
        if (out_v[d] !== exp) $display("FAIL result d%0d x=%h: got %b expected %b", d, x, out_v[d], exp);
        else passes++;
        checks++;
        if (busy_v[d] !== 1'b0) $display("FAIL busy_done d%0d: got %b expected 0", d, busy_v[d]);
        else passes++;
        out_ready_v[d] = 1'b1;
        #1;
        checks++;
        if (in_ready_v[d] !== 1'b1) $display("FAIL in_ready_follow d%0d: got %b expected 1", d, in_ready_v[d]);
        else passes++;
        @(posedge clk); #1;
        out_ready_v[d] = 1'b0;
        checks++;
        if (out_valid_v[d] !== 1'b0 || out_v[d] !== exp)
            $display("FAIL consume d%0d: got valid=%b out=%b expected valid=0 out=%b", d, out_valid_v[d], out_v[d], exp);
        else passes++;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        in_data_v   = '0;
        in_valid_v  = '0;
        out_ready_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || out_v[d] !== 4'b0)
                $display("FAIL reset d%0d: got in_ready=%b out_valid=%b busy=%b out=%b expected 1 0 0 0000",
                         d, in_ready_v[d], out_valid_v[d], busy_v[d], out_v[d]);
            else passes++;
        end
    endtask

    task automatic test_basic();
        // features [3,5,2,7]: sums 17 and -7
        run_vec(0, {4'd7, 4'd2, 4'd5, 4'd3}, 4'b0001);
        run_vec(1, {4'd7, 4'd2, 4'd5, 4'd3}, 4'b0001);
    endtask

    task automatic test_threshold();
        run_vec(2, {4'd7, 4'd2, 4'd5, 4'd3}, 4'b0001);
    endtask

    task automatic test_extremes();
        run_vec(3, 16'hFFFF, 4'b0101);
    endtask

    task automatic test_random();
        logic [15:0] x;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 6; i++) begin
                x = 16'($urandom);
                run_vec(d, x, model(d, x));
            end
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [15:0] x1, x2, x3;
        int k;
        x1 = 16'($urandom);
        x2 = 16'($urandom);
        x3 = 16'($urandom);
        in_data_v[d]   = x1;
        in_valid_v[d]  = 1'b1;
        out_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        in_data_v[d] = x2;
        checks++;
        if (in_ready_v[d] !== 1'b0) $display("FAIL b2b_run_ready d%0d: got %b expected 0", d, in_ready_v[d]);
        else passes++;
        wait_valid(d, k);
        checks++;
        if (k !== BEATS_T[d] || out_v[d] !== model(d, x1))
            $display("FAIL b2b_first d%0d: got lat=%0d out=%b expected lat=%0d out=%b", d, k, out_v[d], BEATS_T[d], model(d, x1));
        else passes++;
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        checks++;
        if (out_valid_v[d] !== 1'b0 || busy_v[d] !== 1'b1)
            $display("FAIL b2b_accept d%0d: got valid=%b busy=%b expected 0 1", d, out_valid_v[d], busy_v[d]);
        else passes++;
        out_ready_v[d] = 1'b0;
        wait_valid(d, k);
        checks++;
        if (k !== BEATS_T[d] || out_v[d] !== model(d, x2))
            $display("FAIL b2b_second d%0d: got lat=%0d out=%b expected lat=%0d out=%b", d, k, out_v[d], BEATS_T[d], model(d, x2));
        else passes++;
        in_data_v[d]  = x3;
        in_valid_v[d] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_v[d] !== 1'b1 || out_v[d] !== model(d, x2) || in_ready_v[d] !== 1'b0)
                $display("FAIL stall d%0d c%0d: got valid=%b out=%b in_ready=%b expected 1 %b 0",
                         d, c, out_valid_v[d], out_v[d], in_ready_v[d], model(d, x2));
            else passes++;
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[d] = 1'b0;
        checks++;
        if (out_valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0)
            $display("FAIL b2b_drain d%0d: got valid=%b busy=%b expected 0 0", d, out_valid_v[d], busy_v[d]);
        else passes++;
    endtask

    task automatic test_reset_midrun();
        logic [15:0] y;
        int bad;
        bad = 0;
        in_data_v[0]  = 16'hFFFF;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || out_v[0] !== 4'b0)
            $display("FAIL midrun_reset: got valid=%b busy=%b out=%b expected 0 0 0000", out_valid_v[0], busy_v[0], out_v[0]);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_v[0] !== 1'b1) $display("FAIL midrun_ready: got %b expected 1", in_ready_v[0]);
        else passes++;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid_v[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL midrun_no_result: got %0d cycles with out_valid expected 0", bad);
        else passes++;
        y = {4'd1, 4'd9, 4'd4, 4'd6};
        run_vec(0, y, model(0, y));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_extremes();
        test_random();
        test_back_to_back(0);
        test_back_to_back(3);
        test_back_to_back(2);
        test_reset_midrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
